// File: rtl/rv32i_memory_map_pkg.sv
// Shared types and default SoC memory map for the rv32i data-port bus decoder.
package rv32i_memory_map_pkg;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [1:0] CauseNone     = 2'd0;
  localparam logic [1:0] CauseUnmapped = 2'd1;
  localparam logic [1:0] CauseTimeout  = 2'd2;
  localparam logic [1:0] CauseRdWr     = 2'd3;

  // Region order: MMIO, RAM, ROM, GPU (index 0 is highest priority on overlap).
  localparam int unsigned DefNumRegions = 4;
  localparam logic [4*32-1:0] DefRegionBase =
    {32'h0005_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [4*32-1:0] DefRegionEnd =
    {32'h0006_0000, 32'h0003_0000, 32'h0002_0000, 32'h0000_0040};
  localparam logic [4*4-1:0] DefRegionWait = {4'd2, 4'd3, 4'd0, 4'd0};

endpackage

// File: rtl/rv32i_memory_map_region_decode.sv
// Combinational priority address decoder: lowest-index matching region wins.
module rv32i_memory_map_region_decode #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NUM_REGIONS = 4,
  parameter logic [NUM_REGIONS*XLEN-1:0] REGION_BASE = '0,
  parameter logic [NUM_REGIONS*XLEN-1:0] REGION_END = '0
) (
  input  logic [XLEN-1:0]        addr_i,
  output logic [NUM_REGIONS-1:0] hit_o,
  output logic [3:0]             idx_o,
  output logic                   any_o
);

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    hit_o = '0;
    for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
      if (addr_i >= REGION_BASE[k*XLEN +: XLEN] && addr_i < REGION_END[k*XLEN +: XLEN]) begin
        idx_o = 4'(k);
        any_o = 1'b1;
      end
    end
    for (int k = 0; k < NUM_REGIONS; k++) begin
      hit_o[k] = any_o && (idx_o == 4'(k));
    end
  end

endmodule

// File: rtl/rv32i_memory_map.sv
// Bus decoder/controller between the rv32i data port and N memory-mapped regions:
// registered request, per-region wait states, ready timeout and sticky fault capture.
module rv32i_memory_map
  import rv32i_memory_map_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PORT_LEN = 32,
  parameter int unsigned NUM_REGIONS = DefNumRegions,
  parameter logic [NUM_REGIONS*XLEN-1:0] REGION_BASE = DefRegionBase,
  parameter logic [NUM_REGIONS*XLEN-1:0] REGION_END = DefRegionEnd,
  parameter logic [NUM_REGIONS*4-1:0] REGION_WAIT = DefRegionWait,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            read_i,
  input  logic                            write_i,
  input  logic [XLEN-1:0]                 addr_i,
  input  logic [PORT_LEN-1:0]             data_i,
  input  logic [NUM_REGIONS*PORT_LEN-1:0] dev_data_i,
  input  logic [NUM_REGIONS-1:0]          dev_ready_i,
  input  logic                            fault_clear_i,
  output logic [NUM_REGIONS-1:0]          region_sel_o,
  output logic                            dev_read_o,
  output logic                            dev_write_o,
  output logic [XLEN-1:0]                 dev_addr_o,
  output logic [PORT_LEN-1:0]             dev_data_o,
  output logic [PORT_LEN-1:0]             data_o,
  output logic                            ready_o,
  output logic                            err_o,
  output logic                            fault_o,
  output logic [XLEN-1:0]                 fault_addr_o,
  output logic [1:0]                      fault_cause_o
);

  localparam int unsigned ToW = $clog2(TIMEOUT + 1);

  logic [NUM_REGIONS-1:0] hit;
  logic [3:0]             hit_idx;
  logic                   hit_any;

  rv32i_memory_map_region_decode #(
    .XLEN        (XLEN),
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_END  (REGION_END)
  ) u_decode (
    .addr_i (addr_i),
    .hit_o  (hit),
    .idx_o  (hit_idx),
    .any_o  (hit_any)
  );

  state_e                 state_q, state_d;
  logic [NUM_REGIONS-1:0] sel_q, sel_d;
  logic                   rd_q, rd_d, wr_q, wr_d;
  logic [XLEN-1:0]        addr_q, addr_d, dev_addr_q, dev_addr_d;
  logic [PORT_LEN-1:0]    dev_data_q, dev_data_d, data_q, data_d;
  logic                   ready_q, ready_d, err_q, err_d;
  logic [3:0]             wait_q, wait_d;
  logic [ToW-1:0]         to_q, to_d;
  logic                   fault_q, fault_d;
  logic [XLEN-1:0]        fault_addr_q, fault_addr_d;
  logic [1:0]             fault_cause_q, fault_cause_d;

  logic [XLEN-1:0]     base_sel;
  logic [3:0]          wait_sel;
  logic                cur_ready;
  logic [PORT_LEN-1:0] cur_data;
  logic                accept, req_bad, busy_live, done_ok, timed_out, err_now;

  always_comb begin
    base_sel = '0;
    wait_sel = '0;
    cur_data = '0;
    for (int k = 0; k < NUM_REGIONS; k++) begin
      if (hit_idx == 4'(k)) begin
        base_sel = REGION_BASE[k*XLEN +: XLEN];
        wait_sel = REGION_WAIT[k*4 +: 4];
      end
      if (sel_q[k]) cur_data = dev_data_i[k*PORT_LEN +: PORT_LEN];
    end
  end

  assign cur_ready = |(dev_ready_i & sel_q);
  // ready_q blocks re-acceptance of the request the core still holds during its ready_o cycle.
  assign accept    = (state_q == StIdle) && (read_i || write_i) && !ready_q;
  assign req_bad   = (read_i && write_i) || !hit_any;
  assign busy_live = (state_q == StBusy) && (wait_q == 4'd0);
  assign done_ok   = busy_live && cur_ready;
  assign timed_out = busy_live && !cur_ready && (to_q == ToW'(TIMEOUT - 1));
  assign err_now   = (accept && req_bad) || timed_out;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept && !req_bad) state_d = StBusy;
      StBusy: if (done_ok || timed_out) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sel_d         = sel_q;
    rd_d          = rd_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    dev_addr_d    = dev_addr_q;
    dev_data_d    = dev_data_q;
    data_d        = data_q;
    ready_d       = 1'b0;
    err_d         = 1'b0;
    wait_d        = wait_q;
    to_d          = to_q;
    fault_d       = fault_q;
    fault_addr_d  = fault_addr_q;
    fault_cause_d = fault_cause_q;

    if (accept && !req_bad) begin
      sel_d      = hit;
      rd_d       = read_i;
      wr_d       = write_i;
      addr_d     = addr_i;
      dev_addr_d = addr_i - base_sel;
      dev_data_d = data_i;
      wait_d     = wait_sel;
      to_d       = '0;
    end
    if (state_q == StBusy) begin
      if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
      else if (!cur_ready && !timed_out) to_d = to_q + ToW'(1);
    end
    if (done_ok || timed_out) begin
      sel_d   = '0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      ready_d = 1'b1;
    end
    if (done_ok && rd_q) data_d = cur_data;
    if (err_now) begin
      ready_d = 1'b1;
      err_d   = 1'b1;
      data_d  = '0;
    end

    // A new error in the same cycle as a clear is recorded rather than dropped.
    if (err_now && (!fault_q || fault_clear_i)) begin
      fault_d       = 1'b1;
      fault_addr_d  = timed_out ? addr_q : addr_i;
      fault_cause_d = timed_out ? CauseTimeout :
                      (read_i && write_i) ? CauseRdWr : CauseUnmapped;
    end else if (fault_clear_i) begin
      fault_d       = 1'b0;
      fault_addr_d  = '0;
      fault_cause_d = CauseNone;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sel_q         <= '0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      dev_addr_q    <= '0;
      dev_data_q    <= '0;
      data_q        <= '0;
      ready_q       <= 1'b0;
      err_q         <= 1'b0;
      wait_q        <= '0;
      to_q          <= '0;
      fault_q       <= 1'b0;
      fault_addr_q  <= '0;
      fault_cause_q <= CauseNone;
    end else begin
      sel_q         <= sel_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      dev_addr_q    <= dev_addr_d;
      dev_data_q    <= dev_data_d;
      data_q        <= data_d;
      ready_q       <= ready_d;
      err_q         <= err_d;
      wait_q        <= wait_d;
      to_q          <= to_d;
      fault_q       <= fault_d;
      fault_addr_q  <= fault_addr_d;
      fault_cause_q <= fault_cause_d;
    end
  end

  assign region_sel_o  = sel_q;
  assign dev_read_o    = rd_q;
  assign dev_write_o   = wr_q;
  assign dev_addr_o    = dev_addr_q;
  assign dev_data_o    = dev_data_q;
  assign data_o        = data_q;
  assign ready_o       = ready_q;
  assign err_o         = err_q;
  assign fault_o       = fault_q;
  assign fault_addr_o  = fault_addr_q;
  assign fault_cause_o = fault_cause_q;

endmodule

// File: tb/tb_rv32i_memory_map.sv
// Directed bench for rv32i_memory_map with a transaction-level model of the region map.
module tb_rv32i_memory_map;

  localparam int unsigned TO = 16;
  localparam logic [127:0] PBase = {32'h0005_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [127:0] PEnd  = {32'h0006_0000, 32'h0003_0000, 32'h0002_0000, 32'h0000_0040};
  localparam logic [15:0]  PWait = {4'd2, 4'd3, 4'd0, 4'd0};

  logic [31:0] m_base [4] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h0005_0000};
  logic [31:0] m_end  [4] = '{32'h0000_0040, 32'h0002_0000, 32'h0003_0000, 32'h0006_0000};
  int          m_wait [4] = '{0, 0, 3, 2};
  logic [31:0] m_dev  [4] = '{32'h1111_0000, 32'hDEAD_BEEF, 32'hC0DE_0003, 32'h6060_6060};

  logic         clk = 1'b0;
  logic         reset_i, read_i, write_i, fault_clear_i;
  logic [31:0]  addr_i, data_i;
  logic [127:0] dev_data_i;
  logic [3:0]   dev_ready_i;
  logic [3:0]   region_sel_o;
  logic         dev_read_o, dev_write_o, ready_o, err_o, fault_o;
  logic [31:0]  dev_addr_o, dev_data_o, data_o, fault_addr_o;
  logic [1:0]   fault_cause_o;

  assign dev_data_i = {m_dev[3], m_dev[2], m_dev[1], m_dev[0]};

  rv32i_memory_map #(
    .XLEN        (32),
    .PORT_LEN    (32),
    .NUM_REGIONS (4),
    .REGION_BASE (PBase),
    .REGION_END  (PEnd),
    .REGION_WAIT (PWait),
    .TIMEOUT     (TO)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .read_i        (read_i),
    .write_i       (write_i),
    .addr_i        (addr_i),
    .data_i        (data_i),
    .dev_data_i    (dev_data_i),
    .dev_ready_i   (dev_ready_i),
    .fault_clear_i (fault_clear_i),
    .region_sel_o  (region_sel_o),
    .dev_read_o    (dev_read_o),
    .dev_write_o   (dev_write_o),
    .dev_addr_o    (dev_addr_o),
    .dev_data_o    (dev_data_o),
    .data_o        (data_o),
    .ready_o       (ready_o),
    .err_o         (err_o),
    .fault_o       (fault_o),
    .fault_addr_o  (fault_addr_o),
    .fault_cause_o (fault_cause_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  int start_cyc = 0;
  int last_lat = -1;

  // Model state and per-cycle expectations.
  logic [31:0] m_data, m_faddr;
  logic        m_fault;
  logic [1:0]  m_cause;
  logic [3:0]  exp_sel;
  logic        exp_rd, exp_wr, exp_ready, exp_err;
  logic [31:0] exp_daddr, exp_ddata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < 4; k++) if (a >= m_base[k] && a < m_end[k]) return k;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready_o", 32'(ready_o), 32'(exp_ready));
      check("err_o", 32'(err_o), 32'(exp_err));
      check("region_sel_o", 32'(region_sel_o), 32'(exp_sel));
      check("dev_read_o", 32'(dev_read_o), 32'(exp_rd));
      check("dev_write_o", 32'(dev_write_o), 32'(exp_wr));
      check("data_o", data_o, m_data);
      check("fault_o", 32'(fault_o), 32'(m_fault));
      check("fault_cause_o", 32'(fault_cause_o), 32'(m_cause));
      check("fault_addr_o", fault_addr_o, m_faddr);
      if (exp_rd || exp_wr) begin
        check("dev_addr_o", dev_addr_o, exp_daddr);
        check("dev_data_o", dev_data_o, exp_ddata);
      end
      if (ready_o) last_lat = cyc - start_cyc;
    end
  end

  task automatic set_idle_exp();
    exp_sel = '0; exp_rd = 1'b0; exp_wr = 1'b0; exp_ready = 1'b0; exp_err = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      read_i = 1'b0; write_i = 1'b0; fault_clear_i = 1'b0; dev_ready_i = 4'h0;
      set_idle_exp();
    end
  endtask

  // One core access held until its ready_o cycle; returns at the start of that cycle.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input bit rdy, input bit clr);
    int k, lat;
    bit bad, err;
    k   = decode(a);
    bad = (k < 0) || (rd && wr);
    err = bad || !rdy;
    if (bad) lat = 1;
    else if (rdy) lat = 2 + m_wait[k];
    else lat = 1 + m_wait[k] + int'(TO);
    for (int c = 0; c <= lat; c++) begin
      @(posedge clk); #1;
      if (c == 0) start_cyc = cyc;
      read_i = rd; write_i = wr; addr_i = a; data_i = d;
      dev_ready_i = rdy ? 4'hF : 4'h0;
      fault_clear_i = clr && (c == 0);
      exp_rd    = !bad && rd && c >= 1 && c < lat;
      exp_wr    = !bad && wr && c >= 1 && c < lat;
      exp_sel   = (!bad && c >= 1 && c < lat) ? 4'(1 << k) : 4'h0;
      exp_daddr = bad ? 32'h0 : a - m_base[k];
      exp_ddata = d;
      exp_ready = (c == lat);
      exp_err   = (c == lat) && err;
      if (c == 1 && clr && !(bad && lat == 1)) begin
        m_fault = 1'b0; m_cause = 2'd0; m_faddr = 32'h0;
      end
      if (c == lat) begin
        if (err) begin
          m_data = 32'h0;
          if (!m_fault || (clr && lat == 1)) begin
            m_fault = 1'b1;
            m_faddr = a;
            m_cause = (rd && wr) ? 2'd3 : (k < 0) ? 2'd1 : 2'd2;
          end
        end else if (rd) begin
          m_data = m_dev[k];
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; read_i = 1'b0; write_i = 1'b0; fault_clear_i = 1'b0;
    addr_i = '0; data_i = '0; dev_ready_i = '0;
    m_data = '0; m_faddr = '0; m_fault = 1'b0; m_cause = 2'd0;
    exp_daddr = '0; exp_ddata = '0;
    set_idle_exp();
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    check("rst_ready", 32'(ready_o), 32'h0);
    check("rst_fault", 32'(fault_o), 32'h0);
    check("rst_data", data_o, 32'h0);
    check("rst_sel", 32'(region_sel_o), 32'h0);
    chk_en = 1'b1;
    idle(2);

    access(1'b1, 1'b0, 32'h0001_0004, 32'h0, 1'b1, 1'b0);
    idle(1);
    check("lit_ram_data", data_o, 32'hDEAD_BEEF);
    check("lit_ram_lat", 32'(last_lat), 32'd2);

    access(1'b1, 1'b0, 32'h0002_0010, 32'h0, 1'b1, 1'b0);
    idle(1);
    check("lit_rom_lat", 32'(last_lat), 32'd5);

    // Back-to-back: MMIO write (data_o kept) then read at the last MMIO byte.
    access(1'b0, 1'b1, 32'h0000_003C, 32'hA5A5_1234, 1'b1, 1'b0);
    access(1'b1, 1'b0, 32'h0000_003F, 32'h0, 1'b1, 1'b0);
    idle(1);

    access(1'b1, 1'b0, 32'h0003_0000, 32'h0, 1'b1, 1'b0);
    idle(1);
    check("lit_unmap_lat", 32'(last_lat), 32'd1);
    check("lit_unmap_cause", 32'(fault_cause_o), 32'd1);
    check("lit_unmap_addr", fault_addr_o, 32'h0003_0000);

    access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 1'b0);
    access(1'b0, 1'b1, 32'h0005_0008, 32'h0000_0077, 1'b0, 1'b0);
    idle(1);
    check("lit_to_lat", 32'(last_lat), 32'd19);
    check("lit_sticky_addr", fault_addr_o, 32'h0003_0000);

    access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 1'b1);
    idle(1);
    check("lit_clr_err_fault", 32'(fault_o), 32'd1);
    check("lit_clr_err_addr", fault_addr_o, 32'h0000_0040);

    access(1'b1, 1'b0, 32'h0001_0000, 32'h0, 1'b1, 1'b1);
    idle(1);
    check("lit_clr_fault", 32'(fault_o), 32'd0);

    access(1'b0, 1'b1, 32'h0005_0008, 32'h0000_0099, 1'b0, 1'b0);
    idle(1);
    check("lit_to_cause", 32'(fault_cause_o), 32'd2);
    check("lit_to_addr", fault_addr_o, 32'h0005_0008);

    access(1'b1, 1'b1, 32'h0001_0000, 32'h0, 1'b1, 1'b1);
    idle(1);
    check("lit_rw_cause", 32'(fault_cause_o), 32'd3);

    // Asynchronous reset in the middle of a ROM wait sequence.
    chk_en = 1'b0;
    @(posedge clk); #1;
    read_i = 1'b1; addr_i = 32'h0002_0020; dev_ready_i = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_read", 32'(dev_read_o), 32'd1);
    #2 reset_i = 1'b1;
    #1;
    check("arst_read", 32'(dev_read_o), 32'd0);
    check("arst_sel", 32'(region_sel_o), 32'd0);
    check("arst_fault", 32'(fault_o), 32'd0);
    check("arst_cause", 32'(fault_cause_o), 32'd0);
    check("arst_data", data_o, 32'd0);
    check("arst_ready", 32'(ready_o), 32'd0);
    @(posedge clk); #1;
    reset_i = 1'b0; read_i = 1'b0;
    m_data = '0; m_faddr = '0; m_fault = 1'b0; m_cause = 2'd0;
    set_idle_exp();
    chk_en = 1'b1;
    idle(6);

    access(1'b1, 1'b0, 32'h0001_0008, 32'h0, 1'b1, 1'b0);
    idle(1);
    check("lit_post_rst_data", data_o, 32'hDEAD_BEEF);
    check("lit_post_rst_lat", 32'(last_lat), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
